battle_sequencer: RTL and testbench

Sequences one melee encounter between the player and the enemy occupying a map tile. It drives the enemy stat lookup tables (attack, defense, HP) with the enemy's tile id, then alternates paced strikes until one side reaches 0 HP. It sits between the movement/interaction logic, which issues `start`, and the player-stat registers, which take `hp_out` on `hp_we`. It also emits per-strike pulses for animation and sound.

---
 rtl/battle_sequencer.sv | 163 ++++++++++++++++
 tb/tb_battle_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/battle_sequencer.sv
// Melee encounter sequencer: loads enemy stats through the lookup port, then
// alternates paced player/enemy strikes until one side is at 0 HP.
module battle_sequencer #(
    parameter int TILE_W       = 8,
    parameter int ROUND_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TILE_W-1:0] tile_id,
    input  logic [15:0]       player_hp,
    input  logic [15:0]       player_atk,
    input  logic [15:0]       player_def,
    output logic [TILE_W-1:0] lk_tile,
    input  logic [15:0]       lk_attack,
    input  logic [15:0]       lk_defense,
    input  logic [15:0]       lk_hp,
    output logic              busy,
    output logic              done,
    output logic              win,
    output logic [15:0]       hp_out,
    output logic              hp_we,
    output logic [15:0]       enemy_hp_out,
    output logic              strike,
    output logic [7:0]        rounds
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | lookups driven with latched tile, damage computed
    // P_HIT  | player strikes enemy
    // P_WAIT | pacing after player strike
    // E_HIT  | enemy strikes player
    // E_WAIT | pacing after enemy strike
    // FINISH | done/hp_we/win presented for one cycle
    typedef enum logic [2:0] {
        IDLE, LOAD, P_HIT, P_WAIT, E_HIT, E_WAIT, FINISH
    } state_t;

    localparam logic [7:0] WAIT_LOAD = 8'(ROUND_CYCLES - 1);

    state_t            state;
    logic [TILE_W-1:0] tile_q;
    logic [15:0]       php;
    logic [15:0]       patk;
    logic [15:0]       pdef;
    logic [15:0]       pdmg;
    logic [15:0]       edmg;
    logic [15:0]       ehp;
    logic [7:0]        wait_cnt;

    logic [15:0] load_pdmg;
    logic [15:0] load_edmg;
    logic [15:0] ehp_next;
    logic [15:0] php_next;

    always_comb begin
        load_pdmg = (patk > lk_defense) ? patk - lk_defense : 16'd0;
        load_edmg = (lk_attack > pdef) ? lk_attack - pdef : 16'd0;
        ehp_next  = (ehp > pdmg) ? ehp - pdmg : 16'd0;
        php_next  = (php > edmg) ? php - edmg : 16'd0;
    end

    assign lk_tile      = tile_q;
    assign busy         = (state != IDLE);
    assign enemy_hp_out = ehp;

    // strike/done/hp_we are set on entry to the state they belong to, so they
    // are high exactly during P_HIT/E_HIT and FINISH respectively.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tile_q   <= '0;
            php      <= '0;
            patk     <= '0;
            pdef     <= '0;
            pdmg     <= '0;
            edmg     <= '0;
            ehp      <= '0;
            wait_cnt <= '0;
            done     <= 1'b0;
            win      <= 1'b0;
            hp_out   <= '0;
            hp_we    <= 1'b0;
            strike   <= 1'b0;
            rounds   <= '0;
        end else begin
            strike <= 1'b0;
            done   <= 1'b0;
            hp_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tile_q <= tile_id;
                        php    <= player_hp;
                        patk   <= player_atk;
                        pdef   <= player_def;
                        rounds <= '0;
                        win    <= 1'b0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    ehp  <= lk_hp;
                    pdmg <= load_pdmg;
                    edmg <= load_edmg;
                    if (lk_hp == 16'd0 || load_pdmg == 16'd0) begin
                        win    <= (lk_hp == 16'd0);
                        done   <= 1'b1;
                        hp_we  <= 1'b1;
                        hp_out <= php;
                        state  <= FINISH;
                    end else begin
                        strike <= 1'b1;
                        state  <= P_HIT;
                    end
                end
                P_HIT: begin
                    ehp      <= ehp_next;
                    wait_cnt <= WAIT_LOAD;
                    state    <= P_WAIT;
                end
                P_WAIT: begin
                    if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else if (ehp == 16'd0) begin
                        win    <= 1'b1;
                        done   <= 1'b1;
                        hp_we  <= 1'b1;
                        hp_out <= php;
                        state  <= FINISH;
                    end else begin
                        strike <= 1'b1;
                        state  <= E_HIT;
                    end
                end
                E_HIT: begin
                    php      <= php_next;
                    rounds   <= (rounds == 8'd255) ? rounds : rounds + 8'd1;
                    wait_cnt <= WAIT_LOAD;
                    state    <= E_WAIT;
                end
                E_WAIT: begin
                    if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else if (php == 16'd0) begin
                        win    <= 1'b0;
                        done   <= 1'b1;
                        hp_we  <= 1'b1;
                        hp_out <= php;
                        state  <= FINISH;
                    end else begin
                        strike <= 1'b1;
                        state  <= P_HIT;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_battle_sequencer.sv
// Bench for battle_sequencer: directed encounters plus randomized ones, each
// compared against an outcome model computed from the battle rules.
module tb_battle_sequencer;

    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  tile_id;
    logic [15:0] player_hp, player_atk, player_def;
    logic [7:0]  lk_tile;
    logic [15:0] lk_attack, lk_defense, lk_hp;
    logic        busy, done, win, hp_we, strike;
    logic [15:0] hp_out, enemy_hp_out;
    logic [7:0]  rounds;

    logic [15:0] atk_tab [256];
    logic [15:0] def_tab [256];
    logic [15:0] hp_tab  [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign lk_attack  = atk_tab[lk_tile];
    assign lk_defense = def_tab[lk_tile];
    assign lk_hp      = hp_tab[lk_tile];

    battle_sequencer #(.TILE_W(8), .ROUND_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tile_id(tile_id),
        .player_hp(player_hp), .player_atk(player_atk), .player_def(player_def),
        .lk_tile(lk_tile), .lk_attack(lk_attack), .lk_defense(lk_defense), .lk_hp(lk_hp),
        .busy(busy), .done(done), .win(win), .hp_out(hp_out), .hp_we(hp_we),
        .enemy_hp_out(enemy_hp_out), .strike(strike), .rounds(rounds)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Whole-battle outcome from the rules: strike-by-strike HP arithmetic.
    function automatic void model(input int ph, input int pa, input int pd,
                                  input int ea, input int ed, input int eh0,
                                  output int cyc, output int w, output int hpo,
                                  output int rnd, output int strk, output int ehf);
        int pdm, edm, eh, p, n, m;
        pdm = (pa > ed) ? pa - ed : 0;
        edm = (ea > pd) ? ea - pd : 0;
        eh = eh0; p = ph; n = 0; m = 0;
        if (eh0 == 0) begin
            w = 1;
        end else if (pdm == 0) begin
            w = 0;
        end else begin
            w = -1;
            while (w < 0) begin
                eh = (eh > pdm) ? eh - pdm : 0;
                n++;
                if (eh == 0) w = 1;
                else begin
                    p = (p > edm) ? p - edm : 0;
                    m++;
                    if (p == 0) w = 0;
                end
            end
        end
        cyc  = 2 + (n + m) * (1 + RC);
        hpo  = p;
        rnd  = (m > 255) ? 255 : m;
        strk = n + m;
        ehf  = eh;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_win"},    win, 0);
        chk({tag, "_hp_out"}, hp_out, 0);
        chk({tag, "_hp_we"},  hp_we, 0);
        chk({tag, "_ehp"},    enemy_hp_out, 0);
        chk({tag, "_strike"}, strike, 0);
        chk({tag, "_rounds"}, rounds, 0);
        chk({tag, "_lk_tile"}, lk_tile, 0);
    endtask

    // Entered at a negedge with the DUT idle; start is driven in that cycle (cycle 0).
    task automatic run_battle(input string tag, input logic [7:0] t, input logic [15:0] ph,
                              input logic [15:0] pa, input logic [15:0] pd, input bit abuse);
        int ecyc, ew, ehpo, ernd, estr, eehp;
        int done_cyc, strikes, busy_bad, tile_bad;
        logic o_win, o_we;
        logic [15:0] o_hp, o_ehp;
        logic [7:0] o_rnd;
        model(int'(ph), int'(pa), int'(pd), int'(atk_tab[t]), int'(def_tab[t]), int'(hp_tab[t]),
              ecyc, ew, ehpo, ernd, estr, eehp);
        tile_id = t; player_hp = ph; player_atk = pa; player_def = pd; start = 1'b1;
        done_cyc = -1; strikes = 0; busy_bad = 0; tile_bad = 0;
        o_win = 1'bx; o_we = 1'bx; o_hp = 'x; o_ehp = 'x; o_rnd = 'x;
        for (int cyc = 1; cyc <= ecyc + 20 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            tile_id = t;
            if (abuse && (cyc == 3 || cyc == ecyc)) begin
                start = 1'b1;
                tile_id = t ^ 8'h5A;
            end
            if (strike === 1'b1) strikes++;
            if (busy !== 1'b1) busy_bad++;
            if (lk_tile !== t) tile_bad++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                o_win = win; o_we = hp_we; o_hp = hp_out; o_rnd = rounds; o_ehp = enemy_hp_out;
            end
        end
        chk({tag, "_done_cycle"}, done_cyc, ecyc);
        chk({tag, "_win"},        o_win, ew);
        chk({tag, "_hp_we"},      o_we, 1);
        chk({tag, "_hp_out"},     o_hp, ehpo);
        chk({tag, "_rounds"},     o_rnd, ernd);
        chk({tag, "_enemy_hp"},   o_ehp, eehp);
        chk({tag, "_strikes"},    strikes, estr);
        chk({tag, "_busy_bad"},   busy_bad, 0);
        chk({tag, "_tile_bad"},   tile_bad, 0);
        @(negedge clk);
        start = 1'b0;
        tile_id = t;
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_done_after"}, done, 0);
        chk({tag, "_we_after"},   hp_we, 0);
        chk({tag, "_win_held"},   win, ew);
        chk({tag, "_tile_held"},  lk_tile, t);
    endtask

    initial begin
        int pulses;
        logic [7:0] t;
        for (int i = 0; i < 256; i++) begin
            atk_tab[i] = 16'($urandom_range(0, 20));
            def_tab[i] = 16'($urandom_range(0, 15));
            hp_tab[i]  = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
        end
        atk_tab[0] = 16'd0; def_tab[0] = 16'd0; hp_tab[0] = 16'd0;
        atk_tab[1] = 16'd1; def_tab[1] = 16'd2; hp_tab[1] = 16'd20;
        atk_tab[2] = 16'd4; def_tab[2] = 16'd0; hp_tab[2] = 16'd100;
        atk_tab[3] = 16'd7; def_tab[3] = 16'd5; hp_tab[3] = 16'd50;
        atk_tab[4] = 16'd3; def_tab[4] = 16'd9; hp_tab[4] = 16'd300;

        rst_n = 1'b0; start = 1'b0; tile_id = 8'd0;
        player_hp = '0; player_atk = '0; player_def = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_battle("win_multi", 8'd1, 16'd100, 16'd10, 16'd0, 1'b1);
        run_battle("loss", 8'd2, 16'd5, 16'd3, 16'd0, 1'b0);
        run_battle("no_damage", 8'd3, 16'd42, 16'd2, 16'd0, 1'b0);
        run_battle("not_enemy", 8'd0, 16'd17, 16'd9, 16'd1, 1'b0);

        // Abort during E_WAIT (cycles 8..11 of the tile-1 battle).
        tile_id = 8'd1; player_hp = 16'd100; player_atk = 16'd10; player_def = 16'd0;
        start = 1'b1;
        pulses = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1 || hp_we === 1'b1) pulses++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("mid_reset");
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 || hp_we === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("mid_reset_no_done", pulses, 0);
        run_battle("after_reset", 8'd1, 16'd100, 16'd10, 16'd0, 1'b0);

        run_battle("saturate", 8'd4, 16'd77, 16'd10, 16'd5, 1'b0);

        for (int k = 0; k < 20; k++) begin
            t = 8'($urandom_range(5, 255));
            run_battle($sformatf("rand%0d", k), t, 16'($urandom_range(1, 100)),
                       16'($urandom_range(0, 25)), 16'($urandom_range(0, 10)),
                       1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
